// File: rtl/alu_pkg.sv
// Shared widths, FSM encoding and flag layout for the ALU operand/writeback stage.
package alu_pkg;

    localparam int unsigned DW     = 8;
    localparam int unsigned NREG   = 8;
    localparam int unsigned AW     = 3;
    localparam int unsigned FSW    = 4;
    localparam int unsigned SHW    = 3;
    localparam int unsigned FLW    = 4;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } seq_state_t;

    // Writeback controls held while an op is in flight
    typedef struct packed {
        logic [AW-1:0] rd;
        logic          wen;
        logic          setf;
    } wb_ctl_t;

    function automatic logic [FLW-1:0] pack_flags(input logic n, input logic z,
                                                  input logic c, input logic v);
        logic [FLW-1:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Decoder-side op handshake and ALU-side operand/result bus of the sequencer.
interface alu_operand_sequencer_if;
    import alu_pkg::*;

    logic            op_valid;
    logic            op_ready;
    logic [FSW-1:0]  op_fs;
    logic [SHW-1:0]  op_sh;
    logic [AW-1:0]   op_ra;
    logic [AW-1:0]   op_rb;
    logic [AW-1:0]   op_rd;
    logic            op_wen;
    logic            op_setf;
    logic [DW-1:0]   op_imm;
    logic [DW-1:0]   ext_in;

    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic [FSW-1:0]  alu_fs;
    logic [SHW-1:0]  alu_sh;
    logic [DW-1:0]   alu_in;
    logic [DW-1:0]   alu_ink;
    logic [DW-1:0]   alu_f;
    logic            alu_n;
    logic            alu_z;
    logic            alu_c;
    logic            alu_v;

    // The sequencer is the slave of the decoder and drives the ALU operands
    modport slave (
        input  op_valid, op_fs, op_sh, op_ra, op_rb, op_rd, op_wen, op_setf, op_imm, ext_in,
        input  alu_f, alu_n, alu_z, alu_c, alu_v,
        output op_ready, alu_a, alu_b, alu_fs, alu_sh, alu_in, alu_ink
    );

    modport master (
        output op_valid, op_fs, op_sh, op_ra, op_rb, op_rd, op_wen, op_setf, op_imm, ext_in,
        output alu_f, alu_n, alu_z, alu_c, alu_v,
        input  op_ready, alu_a, alu_b, alu_fs, alu_sh, alu_in, alu_ink
    );

endinterface

// File: rtl/regfile_8x8.sv
// 8x8 register file: two operand read ports, one debug read port, one write port; R0 reads 0.
module regfile_8x8
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    input  logic [AW-1:0] i_raddr_b,
    input  logic [AW-1:0] i_dbg_addr,
    output logic [DW-1:0] o_rdata_a,
    output logic [DW-1:0] o_rdata_b,
    output logic [DW-1:0] o_dbg_data
);

    logic [DW-1:0] r_mem [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a  = (i_raddr_a  == '0) ? '0 : r_mem[i_raddr_a];
    assign o_rdata_b  = (i_raddr_b  == '0) ? '0 : r_mem[i_raddr_b];
    assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_operand_sequencer.sv
// Operand/writeback stage around the combinational ALU: one op in flight, IDLE -> EXEC -> WB.
module alu_operand_sequencer
    import alu_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    alu_operand_sequencer_if.slave   bus,
    output logic [FLW-1:0]           flags,
    output logic                     done,
    input  logic [AW-1:0]            dbg_addr,
    output logic [DW-1:0]            dbg_data
);

    seq_state_t     r_state;
    seq_state_t     w_next;
    logic           w_accept;
    logic           w_wb;
    logic           w_we;

    wb_ctl_t        r_ctl;
    logic [DW-1:0]  r_a;
    logic [DW-1:0]  r_b;
    logic [FSW-1:0] r_fs;
    logic [SHW-1:0] r_sh;
    logic [DW-1:0]  r_in;
    logic [DW-1:0]  r_ink;
    logic [FLW-1:0] r_flags;

    logic [DW-1:0]  w_rd_a;
    logic [DW-1:0]  w_rd_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_wb     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.op_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_EXEC;
                end
            end
            S_EXEC: begin
                w_wb   = 1'b1;
                w_next = S_WB;
            end
            S_WB: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operands and writeback controls are captured only at the accept edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctl <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_fs  <= '0;
            r_sh  <= '0;
            r_in  <= '0;
            r_ink <= '0;
        end else if (w_accept) begin
            r_ctl <= '{rd: bus.op_rd, wen: bus.op_wen, setf: bus.op_setf};
            r_a   <= w_rd_a;
            r_b   <= w_rd_b;
            r_fs  <= bus.op_fs;
            r_sh  <= bus.op_sh;
            r_in  <= bus.ext_in;
            r_ink <= bus.op_imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (w_wb && r_ctl.setf) begin
            r_flags <= pack_flags(bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v);
        end
    end

    assign w_we = w_wb && r_ctl.wen && (r_ctl.rd != '0);

    regfile_8x8 u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_we),
        .i_waddr    (r_ctl.rd),
        .i_wdata    (bus.alu_f),
        .i_raddr_a  (bus.op_ra),
        .i_raddr_b  (bus.op_rb),
        .i_dbg_addr (dbg_addr),
        .o_rdata_a  (w_rd_a),
        .o_rdata_b  (w_rd_b),
        .o_dbg_data (dbg_data)
    );

    // Ready is a state decode, held low while reset is asserted
    assign bus.op_ready = (r_state == S_IDLE) && rst_n;
    assign done         = (r_state == S_WB);
    assign flags        = r_flags;
    assign bus.alu_a    = r_a;
    assign bus.alu_b    = r_b;
    assign bus.alu_fs   = r_fs;
    assign bus.alu_sh   = r_sh;
    assign bus.alu_in   = r_in;
    assign bus.alu_ink  = r_ink;

endmodule
